// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: streams consecutive words from the last
// fetch address into a small FIFO and serves core fetches that hit its head.
module inst_prefetch_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL    = CNT_W'(DEPTH);
    localparam logic [1:0]            MAX_OUT = 2'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] WORD    = ADDR_WIDTH'(4);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] pf_addr;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [1:0]            outstanding;
    logic [1:0]            drop;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rdata_p1;

    logic                  match;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  mem_fire;
    logic                  rsp_in;
    logic                  push;
    logic                  pop;
    logic                  drop_rsp;
    logic                  space_ok;
    logic [1:0]            live;
    logic [1:0]            out_next;
    logic [CNT_W:0]        fill;

    // The core address is word-aligned by construction; the low bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^instr_addr_i[1:0];

    always_comb begin
        state_d       = state_q;
        match         = (state_q == RUN) &&
                        (instr_addr_i[ADDR_WIDTH-1:2] == head_addr[ADDR_WIDTH-1:2]);
        redirect      = instr_req_i && !match;
        redirect_addr = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};

        // Stale in-flight words no longer reserve FIFO space.
        live     = outstanding - drop;
        fill     = {1'b0, count} + {{(CNT_W-1){1'b0}}, live};
        space_ok = fill < {1'b0, FULL};

        mem_req_o   = (state_q == RUN) && !redirect && (outstanding < MAX_OUT) && space_ok;
        mem_addr_o  = pf_addr;
        mem_fire    = mem_req_o && mem_gnt_i;
        instr_gnt_o = instr_req_i && match && (count != '0);

        // A response with nothing outstanding (e.g. arriving after reset) is ignored.
        rsp_in   = mem_rvalid_i && (outstanding != 2'd0);
        push     = rsp_in && !redirect && (drop == 2'd0);
        drop_rsp = rsp_in && !redirect && (drop != 2'd0);
        pop      = instr_gnt_o;
        out_next = outstanding + {1'b0, mem_fire} - {1'b0, rsp_in};

        if (redirect) begin
            state_d = RUN;
        end

        instr_rvalid_o = vld_p1;
        instr_rdata_o  = vld_p1 ? rdata_p1 : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pf_addr     <= '0;
            head_addr   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= 2'd0;
            drop        <= 2'd0;
            vld_p1      <= 1'b0;
        end else begin
            outstanding <= out_next;
            vld_p1      <= pop;
            if (redirect) begin
                // Everything still in flight belongs to the abandoned stream.
                drop      <= out_next;
                count     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                pf_addr   <= redirect_addr;
                head_addr <= redirect_addr;
            end else begin
                if (drop_rsp) begin
                    drop <= drop - 2'd1;
                end
                if (mem_fire) begin
                    pf_addr <= pf_addr + WORD;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    head_addr <= head_addr + WORD;
                end
                count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
            end
        end
    end

    // ---- stage p0 -> p1: FIFO storage and core response word ----
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata_i;
        end
        if (pop) begin
            rdata_p1 <= fifo_mem[rd_ptr];
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (count == FULL)));

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (outstanding != 2'd0));

    a_drop_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        drop <= outstanding);

    a_outstanding_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding <= MAX_OUT);

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: directed timing scenarios plus a randomized
// core/memory stream checked against an address-to-word memory model.
module tb_inst_prefetch_buffer;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    inst_prefetch_buffer #(
        .DEPTH(4), .MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rsp_t;

    rsp_t          mq[$];
    logic [AW-1:0] mlog[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            last_due = 0;
    int            gnt_pct = 100;
    int            lat = 1;
    bit            rand_lat = 1'b0;
    int            memgnts = 0;
    bit            exp_vld = 1'b0;
    logic [AW-1:0] exp_addr = '0;

    function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},    64'(instr_gnt_o),    64'd0);
        chk({tag, "_rvalid"}, 64'(instr_rvalid_o), 64'd0);
        chk({tag, "_rdata"},  64'(instr_rdata_o),  64'd0);
        chk({tag, "_memreq"}, 64'(mem_req_o),      64'd0);
        chk({tag, "_memadr"}, 64'(mem_addr_o),     64'd0);
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, update models.
    task automatic cycle(input bit req, input logic [AW-1:0] a, output bit g);
        bit rv;
        int d;
        instr_req_i  = req;
        instr_addr_i = a;
        rv           = (mq.size() > 0) && (mq[0].due <= cyc);
        mem_rvalid_i = rv;
        mem_rdata_i  = rv ? memword(mq[0].addr) : $urandom();
        mem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
        #1;
        chk("rvalid", 64'(instr_rvalid_o), 64'(exp_vld));
        if (instr_rvalid_o && exp_vld)
            chk("rdata", 64'(instr_rdata_o), 64'(memword(exp_addr)));
        if (!req)
            chk("gnt_idle", 64'(instr_gnt_o), 64'd0);
        g        = instr_gnt_o;
        exp_vld  = instr_gnt_o;
        exp_addr = {a[AW-1:2], 2'b00};
        if (rv)
            mq.delete(0);
        if (mem_req_o)
            chk("mem_align", 64'(mem_addr_o[1:0]), 64'd0);
        if (mem_req_o && mem_gnt_i) begin
            d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
            if (d <= last_due)
                d = last_due + 1;
            mq.push_back('{mem_addr_o, d});
            last_due = d;
            memgnts++;
            mlog.push_back(mem_addr_o);
            chk("mem_outst", 64'(mq.size() <= MAXO), 64'd1);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic fetch(input logic [AW-1:0] a, output int gc, output bit ok);
        bit g;
        ok = 1'b0;
        gc = -1;
        for (int i = 0; i < 60 && !ok; i++) begin
            cycle(1'b1, a, g);
            if (g) begin
                ok = 1'b1;
                gc = cyc - 1;
            end
        end
        chk("fetch_done", 64'(ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            g, ok;
        int            rc, start, w, out_at, n0, ml;
        int            gc[8];
        int            g4, g8, g12;
        logic [AW-1:0] a;

        rst_n        = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        @(negedge clk);
        @(negedge clk);
        #1 chk_quiet("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, g);
        chk_quiet("after_reset");

        // Sequential stream from 0x0 with an ideal memory.
        rc = cyc;
        for (int i = 0; i < 8; i++)
            fetch(32'(i * 4), gc[i], ok);
        chk("seq_first_lat", 64'(gc[0] - rc), 64'd3);
        for (int i = 1; i < 8; i++)
            chk("seq_back2back", 64'(gc[i] - gc[i-1]), 64'd1);
        cycle(1'b0, '0, g);

        // Branch away while two requests are in flight.
        lat = 2;
        fetch(32'h0, g4, ok);
        fetch(32'h4, g4, ok);
        fetch(32'h8, g4, ok);
        w = 0;
        while (mq.size() != 2 && w < 30) begin
            cycle(1'b0, '0, g);
            w++;
        end
        out_at = mq.size();
        chk("br_outstanding", 64'(out_at), 64'd2);
        lat = 1;
        rc = cyc;
        fetch(32'h100, g4, ok);
        chk("br_gnt_lat", 64'(g4 - rc), 64'd3);
        cycle(1'b0, '0, g);
        chk("br_seen_rvalid", 64'(cyc - 1 - rc), 64'd4);

        // Core stall: prefetching stops once the FIFO space is committed.
        n0 = memgnts;
        fetch(32'h0, g4, ok);
        repeat (10) cycle(1'b0, '0, g);
        chk("stall_fetched", 64'(memgnts - n0), 64'd5);
        chk("stall_req_off", 64'(mem_req_o), 64'd0);
        start = cyc;
        fetch(32'h4, g4, ok);
        fetch(32'h8, g8, ok);
        fetch(32'hC, g12, ok);
        chk("stall_hit0", 64'(g4 - start), 64'd0);
        chk("stall_hit1", 64'(g8 - g4), 64'd1);
        chk("stall_hit2", 64'(g12 - g8), 64'd1);
        cycle(1'b0, '0, g);

        // Address wrap-around.
        ml = mlog.size();
        fetch(32'hFFFF_FFF8, g4, ok);
        fetch(32'hFFFF_FFFC, g4, ok);
        fetch(32'h0000_0000, g4, ok);
        chk("wrap_gnt", 64'(ok), 64'd1);
        chk("wrap_len", 64'(mlog.size() >= ml + 3), 64'd1);
        if (mlog.size() >= ml + 3) begin
            chk("wrap_addr0", 64'(mlog[ml]),   64'hFFFF_FFF8);
            chk("wrap_addr1", 64'(mlog[ml+1]), 64'hFFFF_FFFC);
            chk("wrap_addr2", 64'(mlog[ml+2]), 64'h0000_0000);
        end
        cycle(1'b0, '0, g);

        // Reset mid-stream, right as a granted word is being returned.
        lat = 3;
        fetch(32'h200, g4, ok);
        chk("pre_rst_rvalid", 64'(instr_rvalid_o), 64'd1);
        rst_n        = 1'b0;
        instr_req_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b0;
        #1 chk_quiet("rst_async");
        mq.delete();
        exp_vld = 1'b0;
        @(negedge clk);
        #1 chk_quiet("rst_hold");
        @(negedge clk);
        rst_n    = 1'b1;
        last_due = cyc;
        cycle(1'b0, '0, g);
        chk_quiet("post_rst");
        lat = 1;
        fetch(32'h300, g4, ok);

        // Randomized stream: jumps, one-cycle detours, idle gaps, random memory timing.
        gnt_pct  = 70;
        rand_lat = 1'b1;
        a = 32'h400;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) < 15)
                a = 32'($urandom_range(0, 4095)) << 2;
            else if ($urandom_range(0, 99) < 3)
                a = 32'hFFFF_FFF0;
            if ($urandom_range(0, 99) < 20)
                repeat ($urandom_range(1, 3)) cycle(1'b0, $urandom(), g);
            if ($urandom_range(0, 99) < 10)
                cycle(1'b1, 32'($urandom_range(0, 4095)) << 2, g);
            fetch(a, g4, ok);
            a = a + 32'd4;
        end
        repeat (8) cycle(1'b0, '0, g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
